// File: rtl/usb_tx_serializer.sv
// Full-speed USB transmit serializer: LSB-first shift, bit stuffing,
// NRZI line coding and SE0 end-of-packet, one bit per clock.
module usb_tx_serializer #(
  parameter int STUFF_LEN = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       load_enable,
  input  logic [7:0] data,
  input  logic       eop,
  output logic       d_plus,
  output logic       d_minus,
  output logic       ready
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0] STUFF_TOP = CW'(STUFF_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STUFF,
    EOP
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      sh_q, sh_d;
  logic [3:0]      bit_q, bit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dp_q, dp_d;
  logic            dm_q, dm_d;
  logic            rdy_q, rdy_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    dp_d    = dp_q;
    dm_d    = dm_q;
    rdy_d   = rdy_q;
    if (eop) begin
      state_d = EOP;
      sh_d    = '0;
      bit_d   = '0;
      cnt_d   = '0;
      dp_d    = 1'b0;
      dm_d    = 1'b0;
      rdy_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_enable) begin
            sh_d    = data;
            bit_d   = '0;
            rdy_d   = 1'b0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 4'd1;
          if (sh_q[0]) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            dp_d  = ~dp_q;
            dm_d  = ~dm_q;
          end
          // A full run of ones forces a stuff bit, even after bit 7.
          if (sh_q[0] && cnt_q == STUFF_TOP) begin
            state_d = STUFF;
          end else if (bit_q == 4'd7) begin
            state_d = IDLE;
            rdy_d   = 1'b1;
          end
        end
        STUFF: begin
          cnt_d = '0;
          dp_d  = ~dp_q;
          dm_d  = ~dm_q;
          if (bit_q == 4'd8) begin
            state_d = IDLE;
            rdy_d   = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
        EOP: begin
          dp_d    = 1'b1;
          dm_d    = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          rdy_d   = 1'b1;
        end
      endcase
    end
  end

  assign d_plus  = dp_q;
  assign d_minus = dm_q;
  assign ready   = rdy_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Randomized and directed bench for usb_tx_serializer against a
// queue-based model of the transmitted symbol stream.
module tb_usb_tx_serializer;

  localparam int STUFF_LEN = 6;

  logic       tb_clk = 1'b0;
  logic       tb_n_rst = 1'b0;
  logic       load_enable = 1'b0;
  logic [7:0] data = '0;
  logic       eop = 1'b0;
  logic       d_plus;
  logic       d_minus;
  logic       ready;

  always #5 tb_clk = ~tb_clk;

  usb_tx_serializer #(.STUFF_LEN(STUFF_LEN)) dut (
    .clk        (tb_clk),
    .n_rst      (tb_n_rst),
    .load_enable(load_enable),
    .data       (data),
    .eop        (eop),
    .d_plus     (d_plus),
    .d_minus    (d_minus),
    .ready      (ready)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Model: bits still to be sent (data + stuff), line state, run length.
  bit   m_q[$];
  logic m_dp, m_dm, m_rdy;
  bit   m_in_eop;
  int   m_ones;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dp = 1'b1;
    m_dm = 1'b0;
    m_rdy = 1'b1;
    m_in_eop = 1'b0;
    m_ones = 0;
  endtask

  task automatic model_edge(input logic le, input logic ep,
                            input logic [7:0] d);
    bit b;
    if (ep) begin
      m_q.delete();
      m_dp = 1'b0;
      m_dm = 1'b0;
      m_rdy = 1'b0;
      m_in_eop = 1'b1;
      m_ones = 0;
    end else if (m_in_eop) begin
      m_dp = 1'b1;
      m_dm = 1'b0;
      m_rdy = 1'b1;
      m_in_eop = 1'b0;
    end else if (m_q.size() > 0) begin
      b = m_q.pop_front();
      if (!b) begin
        m_dp = ~m_dp;
        m_dm = ~m_dm;
      end
      m_rdy = (m_q.size() == 0);
    end else if (le) begin
      for (int i = 0; i < 8; i++) begin
        m_q.push_back(d[i]);
        m_ones = d[i] ? m_ones + 1 : 0;
        if (m_ones == STUFF_LEN) begin
          m_q.push_back(1'b0);
          m_ones = 0;
        end
      end
      m_rdy = 1'b0;
    end
  endtask

  task automatic step(input logic le, input logic ep, input logic [7:0] d);
    @(negedge tb_clk);
    load_enable = le;
    eop = ep;
    data = d;
    @(posedge tb_clk);
    model_edge(le, ep, d);
    #1;
    check("d_plus", d_plus, m_dp);
    check("d_minus", d_minus, m_dm);
    check("ready", ready, m_rdy);
    check("no_se1", d_plus & d_minus, 0);
  endtask

  task automatic send(input logic [7:0] d, input int n,
                      output logic [15:0] dps, output logic [15:0] rdys);
    dps = '0;
    rdys = '0;
    step(1'b1, 1'b0, d);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 8'h00);
      dps[i] = d_plus;
      rdys[i] = ready;
    end
  endtask

  logic [15:0] dps, rdys;
  logic        le_r, ep_r;
  logic [7:0]  d_r;

  initial begin
    model_reset();
    #12;
    check("rst_dp", d_plus, 1);
    check("rst_dm", d_minus, 0);
    check("rst_ready", ready, 1);
    @(negedge tb_clk);
    tb_n_rst = 1'b1;
    repeat (3) step(1'b0, 1'b0, 8'h00);

    // SYNC from J
    send(8'h80, 8, dps, rdys);
    check("sync_line", dps[7:0], 8'h2A);
    check("sync_ready", rdys[7:0], 8'h80);

    // clear run length and return to J
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    send(8'hFF, 9, dps, rdys);
    check("ff1_line", dps[8:0], 9'h03F);
    check("ff1_ready", rdys[8:0], 9'h100);
    send(8'hFF, 9, dps, rdys);
    check("ff2_line", dps[8:0], 9'h1F0);
    check("ff2_ready", rdys[8:0], 9'h100);

    // load while busy is dropped
    step(1'b1, 1'b0, 8'h55);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h3C);
    repeat (10) step(1'b0, 1'b0, 8'h00);

    // eop mid-byte for two cycles, then SYNC starts from J
    step(1'b1, 1'b0, 8'hA5);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    check("eop_se0", {d_plus, d_minus, ready}, 3'b000);
    step(1'b0, 1'b1, 8'h00);
    check("eop_se0_2", {d_plus, d_minus, ready}, 3'b000);
    step(1'b0, 1'b0, 8'h00);
    check("eop_j", {d_plus, d_minus, ready}, 3'b101);
    send(8'h80, 8, dps, rdys);
    check("post_eop_sync", dps[7:0], 8'h2A);

    // load together with eop
    step(1'b1, 1'b1, 8'h00);
    check("le_eop_se0", {d_plus, d_minus}, 2'b00);
    step(1'b0, 1'b0, 8'h00);
    repeat (10) step(1'b0, 1'b0, 8'h00);
    check("le_eop_idle", {d_plus, d_minus, ready}, 3'b101);

    // reset mid-byte
    step(1'b1, 1'b0, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    @(negedge tb_clk);
    #2;
    tb_n_rst = 1'b0;
    #1;
    model_reset();
    check("mid_rst_dp", d_plus, 1);
    check("mid_rst_dm", d_minus, 0);
    check("mid_rst_ready", ready, 1);
    @(negedge tb_clk);
    tb_n_rst = 1'b1;
    repeat (4) step(1'b0, 1'b0, 8'h00);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      le_r = ($urandom_range(0, 99) < 40);
      ep_r = ($urandom_range(0, 99) < 3);
      d_r = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      step(le_r, ep_r, d_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
